// File: rtl/pulse_period_meter_if.sv
// Strobe-in / measurement-out bundle for pulse_period_meter.
// The stimulus side uses master and the meter uses slave.
interface pulse_period_meter_if #(
  parameter int N = 8
);
  logic         ena;
  logic         pulse_in;
  logic [N-1:0] ticks;
  logic         valid;
  logic         locked;
  logic         overflow;

  modport master (
    output ena,
    output pulse_in,
    input  ticks,
    input  valid,
    input  locked,
    input  overflow
  );

  modport slave (
    input  ena,
    input  pulse_in,
    output ticks,
    output valid,
    output locked,
    output overflow
  );
endinterface

// File: rtl/pulse_period_meter.sv
// Measures the enabled-clock distance between single-cycle strobes and reports it
// as ticks (period - 1), with lock tracking and a sticky overflow flag.
module pulse_period_meter #(
  parameter int N          = 8,
  parameter int LOCK_COUNT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  pulse_period_meter_if.slave   bus
);

  localparam int MW = $clog2(LOCK_COUNT + 1);

  localparam logic [0:0]    ST_IDLE    = 1'b0;
  localparam logic [0:0]    ST_MEASURE = 1'b1;

  localparam logic [N-1:0]  CNT_ZERO   = {N{1'b0}};
  localparam logic [N-1:0]  CNT_MAX    = {N{1'b1}};
  localparam logic [N-1:0]  CNT_ONE    = N'(1'b1);
  localparam logic [MW-1:0] MATCH_ZERO = {MW{1'b0}};
  localparam logic [MW-1:0] MATCH_ONE  = MW'(1'b1);
  localparam logic [MW-1:0] MATCH_MAX  = MW'(LOCK_COUNT);

  logic [0:0]    state_r,    state_s;
  logic [N-1:0]  cnt_r,      cnt_s;
  logic [N-1:0]  ticks_r,    ticks_s;
  logic [MW-1:0] match_r,    match_s;
  logic          valid_r,    valid_s;
  logic          locked_r,   locked_s;
  logic          overflow_r, overflow_s;

  // Next-state and next-output computation; valid defaults low every cycle.
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    ticks_s    = ticks_r;
    match_s    = match_r;
    valid_s    = 1'b0;
    locked_s   = locked_r;
    overflow_s = overflow_r;

    if (bus.ena) begin
      case (state_r)
        ST_IDLE: begin
          if (bus.pulse_in) begin
            cnt_s   = CNT_ZERO;
            state_s = ST_MEASURE;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_MEASURE: begin
          if (bus.pulse_in) begin
            // A pulse at cnt==max still wins over the overflow path.
            ticks_s    = cnt_r;
            valid_s    = 1'b1;
            cnt_s      = CNT_ZERO;
            overflow_s = 1'b0;
            if ((match_r == MATCH_ZERO) || (cnt_r != ticks_r)) begin
              match_s = MATCH_ONE;
            end else if (match_r < MATCH_MAX) begin
              match_s = match_r + MATCH_ONE;
            end else begin
              match_s = MATCH_MAX;
            end
            locked_s = (match_s == MATCH_MAX);
          end else if (cnt_r == CNT_MAX) begin
            overflow_s = 1'b1;
            match_s    = MATCH_ZERO;
            locked_s   = 1'b0;
            state_s    = ST_IDLE;
          end else begin
            cnt_s = cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_s  = ST_IDLE;
          cnt_s    = CNT_ZERO;
          match_s  = MATCH_ZERO;
          locked_s = 1'b0;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // State and output registers with synchronous reset taking priority over ena.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      cnt_r      <= CNT_ZERO;
      ticks_r    <= CNT_ZERO;
      match_r    <= MATCH_ZERO;
      valid_r    <= 1'b0;
      locked_r   <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      ticks_r    <= ticks_s;
      match_r    <= match_s;
      valid_r    <= valid_s;
      locked_r   <= locked_s;
      overflow_r <= overflow_s;
    end
  end

  assign bus.ticks    = ticks_r;
  assign bus.valid    = valid_r;
  assign bus.locked   = locked_r;
  assign bus.overflow = overflow_r;

endmodule

// File: doc/pulse_period_meter.md
Name: pulse_period_meter

Overview:
Receiving end of the tick-strobe pulse train used across the sigma-delta DAC datapath. It measures the clock distance between successive single-cycle strobes and reports it in the same "ticks" encoding the pulse generator consumes, where period = ticks + 1 clocks. A generator's ticks setting therefore round-trips unchanged. It also reports period lock and overflow. Typical uses: rate checking of DAC update strobes and self-test loopback.

Parameters:
- N, 8, width of the measurement counter and of the ticks output. The maximum measurable period is 2^N clocks.
- LOCK_COUNT, 4, number of consecutive identical measurements required to assert locked. Legal range is 2..15.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- ena  input  1  clock enable. When low, all state holds and pulse_in is ignored.
- pulse_in  input  1  strobe, synchronous to clk. Every ena cycle with pulse_in high counts as one pulse. There is no edge detection, so a constant-high input means a period of 1.
- ticks  output  N  last measured period minus 1; registered.
- valid  output  1  one-cycle strobe: ticks was updated this cycle.
- locked  output  1  high after LOCK_COUNT consecutive equal measurements.
- overflow  output  1  sticky flag: no pulse arrived within 2^N counted cycles.

Behaviour:
- Reset values:
  - ticks=0, valid=0, locked=0, overflow=0.
  - Internal counter cnt=0, match counter=0, state=IDLE.
  - rst has priority over ena.
- Gating: all register updates below happen only on cycles where ena=1. The exception is valid, which is forced to 0 on every cycle that does not produce a measurement, including ena=0 cycles.
- State IDLE:
  - Waiting for a first reference pulse; no measurement is in progress.
  - pulse_in=1: cnt<=0, go to MEASURE. No valid is produced, and ticks is unchanged.
- State MEASURE, pulse_in=1:
  - ticks<=cnt, valid<=1, cnt<=0, overflow<=0.
  - Stay in MEASURE.
- State MEASURE, pulse_in=0 and cnt<2^N-1:
  - cnt<=cnt+1.
- State MEASURE, pulse_in=0 and cnt==2^N-1:
  - overflow<=1, match<=0, locked<=0, go to IDLE.
  - ticks holds its last value.
- Round-trip arithmetic: pulses k enabled cycles apart give ticks=k-1. A generator set to T therefore reads back T, for T in 0..2^N-1.
- Boundary, pulse coincident with cnt==2^N-1: the pulse wins. ticks=2^N-1, valid=1, no overflow.
- Latency: valid and ticks appear one clock after the sampled pulse edge, i.e. the registered output of the pulse cycle.
- Lock tracking, evaluated on each measurement:
  - If match==0, or the new value differs from the current ticks: match<=1.
  - Otherwise: match<=min(match+1, LOCK_COUNT).
  - locked<=1 exactly when the next match equals LOCK_COUNT, so locked rises in the same cycle as the valid that completes the run.
  - A differing measurement drops locked in the same cycle as its valid.
- Overflow clearing: overflow stays set across IDLE and is cleared only by the next valid measurement or by rst.
- Reset mid-operation: rst aborts any measurement. The first pulse after reset is only a reference pulse and produces no valid.
- ena low mid-interval: cnt freezes, so frozen cycles are excluded from the measured period. This matches a generator sharing the same ena.
- Widths: cnt and ticks are N bits, and cnt never wraps. match needs ceil(log2(LOCK_COUNT+1)) bits.

Test Plan:
1. Loopback with a generator at ticks=5 and ena=1:
   - Expect a valid every 6 cycles with ticks=5.
   - locked=1 asserts on the 4th valid; overflow stays 0.
2. pulse_in held constant high:
   - The first cycle enters MEASURE.
   - Expect valid every cycle after that with ticks=0; locked asserts on the 4th valid.
3. Pulses 256 cycles apart (N=8), i.e. cnt reaches 255 as the pulse arrives:
   - Expect ticks=255, valid=1, overflow=0.
4. Overflow and recovery:
   - One pulse, then 256 cycles of silence: expect overflow=1, locked=0.
   - Then two pulses 10 cycles apart: expect ticks=9, valid=1, overflow=0.
5. Lock loss and reacquire:
   - While locked at ticks=5, change the generator to ticks=8.
   - Expect locked to fall with the first valid showing ticks=8, then rise again on the 4th consecutive ticks=8 valid.
6. ena gaps and reset:
   - Pulses 6 enabled cycles apart, with ena low for 3 cycles in between: expect ticks=5.
   - Assert rst mid-interval: next cycle all outputs read 0, and the first post-reset pulse produces no valid.
